sram_1rw_pipe: RTL and testbench
================================

# sram_1rw_pipe

Parametrised single-port (1RW) behavioural SRAM model with request handshake, selectable read latency, read-during-write mode, hardware zero-initialisation and out-of-range address detection. It is the next-generation fake-RAM used to stand in for macro memories in the large-SoC flow designs. It generalises the fixed-size bit-masked 1RW model: width and depth are free, the output no longer goes to X, and a reset-driven init sequencer clears the array. It sits between a cache/queue controller and the physical memory slot the macro will later occupy.

## Interface
- `BITS`, 64: data word width (≥1).
- `WORD_DEPTH`, 32: number of words (≥2, need not be a power of 2).
- `ADDR_WIDTH`, 5: address width; must satisfy 2^ADDR_WIDTH ≥ WORD_DEPTH.
- `READ_LATENCY`, 1: 1 or 2 cycles from request acceptance to response; any other value is an elaboration error.
- `WRITE_FIRST`, 0: 0 = a write returns the old word; 1 = a write returns the merged new word.
- `INIT_ZERO`, 1: 1 = clear the array after reset; 0 = skip init.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_in`  in  1  request present.
- `req_ready_out`  out  1  block can accept a request.
- `addr_in`  in  ADDR_WIDTH  word address.
- `we_in`  in  1  1 = write, 0 = read.
- `wd_in`  in  BITS  write data.
- `w_mask_in`  in  BITS  per-bit write enable.
- `rd_out`  out  BITS  response data.
- `rd_valid_out`  out  1  one-cycle response strobe.
- `err_out`  out  1  response is for an out-of-range address; aligned with `rd_valid_out`.
- `init_done_out`  out  1  high once the array is initialised; stays high until the next reset.

## Operation
- FSM states:
  - **INIT**: entered on reset. A counter `icnt` writes all-zeros to `mem[icnt]` each cycle, running from 0 to WORD_DEPTH-1. When the counter reaches WORD_DEPTH-1, go to RUN.
  - **RUN**: normal operation. The FSM never leaves RUN except on reset.
  - With INIT_ZERO=0, go from INIT to RUN on the first clock after reset deassertion. Array contents are then undefined (X in simulation).
- `req_ready_out` = (state==RUN). A request is accepted when `req_valid_in && req_ready_out`. There is no output backpressure; a new request may be accepted every cycle.
- Accepted write at in-range address `a`: `mem[a] <= (wd_in & w_mask_in) | (mem[a] & ~w_mask_in)`.
- Response data for a write:
  - WRITE_FIRST=0: the pre-write word.
  - WRITE_FIRST=1: the merged word.
- Accepted read returns `mem[a]`.
- Every accepted request, read or write, produces exactly one `rd_valid_out` pulse, in order.
- Out-of-range address (`addr_in ≥ WORD_DEPTH`):
  - A write is dropped and the array is unchanged.
  - The response data is all-zeros, and `err_out=1` on the same cycle as `rd_valid_out`.
- `rd_out` holds its last value when `rd_valid_out=0`; it never goes to X.
- X on `we_in`/`addr_in` during an accepted request (simulation only): the whole array is corrupted to X and a warning is displayed. This matches the existing model.

## Timing
- Reset values (asynchronous):
  - `rd_out`=0, `rd_valid_out`=0, `err_out`=0, `req_ready_out`=0, `init_done_out`=0.
  - Pipeline valids cleared, state=INIT, `icnt`=0.
- Init duration (INIT_ZERO=1): `req_ready_out` and `init_done_out` rise together exactly WORD_DEPTH clocks after the first posedge with `rst_n`=1. With INIT_ZERO=0 they rise after 1 clock.
- Response latency, for a request accepted at edge N:
  - READ_LATENCY=1: `rd_out`/`rd_valid_out`/`err_out` are updated at edge N and visible for one cycle.
  - READ_LATENCY=2: the same outputs are updated at edge N+1.
- Back-to-back write then read of the same address: the read, accepted one cycle later, returns the written data at both latencies. The array is updated at the write's acceptance edge.
- Reset asserted mid-operation: in-flight responses are discarded with no `rd_valid_out`, the array is not guaranteed preserved, and INIT restarts.

## Test plan
- Init: BITS=32, WORD_DEPTH=5, release reset → `req_ready_out`=0 for 5 cycles, then 1. Reading all 5 addresses returns 0x00000000 with `err_out`=0.
- Masked write, READ_LATENCY=1: write 0xFFFFFFFF to addr 3, then write 0x12345678 with mask 0x0000FFFF, then read addr 3 → `rd_out`=0xFFFF5678, with `rd_valid_out` one cycle after the read is accepted.
- WRITE_FIRST: addr 2 holds 0xAAAAAAAA; write 0x55555555 with full mask → the write's response is 0xAAAAAAAA when WRITE_FIRST=0 and 0x55555555 when WRITE_FIRST=1.
- Out of range: WORD_DEPTH=5, write 0xDEADBEEF to addr 6, then read addr 6 → both responses are `rd_out`=0 with `err_out`=1. A full read-back shows addresses 0–4 unchanged.
- Pipelining, READ_LATENCY=2: 8 back-to-back reads of addresses 0..4,0,1,2 → 8 consecutive `rd_valid_out` pulses starting 2 cycles after the first acceptance, with data in order.
- Reset mid-flight: issue 2 reads, assert `rst_n`=0 on the next cycle → no `rd_valid_out`, all outputs 0, and the init sequence reruns.

Source files
------------

// File: rtl/sram_1rw_pipe_if.sv
// sram_1rw_pipe_if: request/response bundle between a memory controller and
// the sram_1rw_pipe fake-RAM.
//
//   req_valid_in   controller -> RAM   request present
//   req_ready_out  RAM -> controller   RAM can accept a request this cycle
//   addr_in        controller -> RAM   word address
//   we_in          controller -> RAM   1 = write, 0 = read
//   wd_in          controller -> RAM   write data
//   w_mask_in      controller -> RAM   per-bit write enable
//   rd_out         RAM -> controller   response data (held between strobes)
//   rd_valid_out   RAM -> controller   one-cycle response strobe
//   err_out        RAM -> controller   response was for an out-of-range address
//   init_done_out  RAM -> controller   array initialisation finished
//
// BITS and ADDR_WIDTH must match the parameters of the attached RAM.
interface sram_1rw_pipe_if #(
    parameter int BITS       = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  we_in;
    logic [BITS-1:0]       wd_in;
    logic [BITS-1:0]       w_mask_in;
    logic [BITS-1:0]       rd_out;
    logic                  rd_valid_out;
    logic                  err_out;
    logic                  init_done_out;

    modport master (
        output req_valid_in, addr_in, we_in, wd_in, w_mask_in,
        input  req_ready_out, rd_out, rd_valid_out, err_out, init_done_out
    );

    modport slave (
        input  req_valid_in, addr_in, we_in, wd_in, w_mask_in,
        output req_ready_out, rd_out, rd_valid_out, err_out, init_done_out
    );
endinterface

// File: rtl/sram_1rw_pipe.sv
// sram_1rw_pipe: parametrised single-port (1RW) behavioural SRAM stand-in.
//
// After reset an init sequencer optionally clears every word, then the RAM
// accepts one request per cycle (read or bit-masked write). Each accepted
// request yields exactly one rd_valid_out strobe, in order, READ_LATENCY
// (1 or 2) edges after acceptance counting the acceptance edge itself.
// Writes return the old word (WRITE_FIRST=0) or the merged word
// (WRITE_FIRST=1). Addresses >= WORD_DEPTH are flagged with err_out, return
// zero data and never modify the array.
//
// Ports:
//   clk    in  single clock, all state on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of sram_1rw_pipe_if (request, response, init status)
module sram_1rw_pipe #(
    parameter int BITS         = 64,
    parameter int WORD_DEPTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0,
    parameter int INIT_ZERO    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_1rw_pipe_if.slave bus
);
    localparam int                  IDX_W   = $clog2(WORD_DEPTH);
    // One extra bit so WORD_DEPTH itself is representable when it equals
    // 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("sram_1rw_pipe: READ_LATENCY must be 1 or 2");
        end
        if ((2 ** ADDR_WIDTH) < WORD_DEPTH) begin : g_bad_addr_width
            $error("sram_1rw_pipe: ADDR_WIDTH too small for WORD_DEPTH");
        end
    endgenerate

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [BITS-1:0] merge_word(
        input logic [BITS-1:0] old_w,
        input logic [BITS-1:0] wr_w,
        input logic [BITS-1:0] mask_w
    );
        return (wr_w & mask_w) | (old_w & ~mask_w);
    endfunction

    logic [BITS-1:0]  mem [WORD_DEPTH];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] icnt_q, icnt_d;
    logic             init_we;

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] addr_idx;
    logic [BITS-1:0]  old_word;
    logic [BITS-1:0]  merged_word;
    logic [BITS-1:0]  resp_data;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [BITS-1:0]  mem_wdata;

    logic             src_vld;
    logic             src_err;
    logic [BITS-1:0]  src_data;

    logic             rd_valid_q, rd_valid_d;
    logic             err_q, err_d;
    logic [BITS-1:0]  rd_q, rd_d;

    // ---------------- control FSM: INIT sweep, then RUN forever ----------------
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (INIT_ZERO != 0) begin
                    init_we = 1'b1;
                    if (icnt_q == IDX_W'(WORD_DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
        end
    end

    assign bus.req_ready_out = (state_q == ST_RUN);
    assign bus.init_done_out = (state_q == ST_RUN);

    // ---------------- request decode and array access ----------------
    always_comb begin
        accept      = bus.req_valid_in && (state_q == ST_RUN);
        in_range    = ({1'b0, bus.addr_in} < DEPTH_L);
        addr_idx    = bus.addr_in[IDX_W-1:0];
        old_word    = in_range ? mem[addr_idx] : '0;
        merged_word = merge_word(old_word, bus.wd_in, bus.w_mask_in);
        if (!in_range) begin
            resp_data = '0;
        end else if (bus.we_in && (WRITE_FIRST != 0)) begin
            resp_data = merged_word;
        end else begin
            resp_data = old_word;
        end
        // Init and accepted requests are mutually exclusive: accept needs RUN.
        mem_we    = init_we || (accept && bus.we_in && in_range);
        mem_waddr = init_we ? icnt_q : addr_idx;
        mem_wdata = init_we ? '0 : merged_word;
    end

`ifndef SYNTHESIS
    // An unknown address or direction on an accepted request could have
    // written anywhere, so the whole array is poisoned.
    logic x_req;
    assign x_req = bus.req_valid_in && (state_q == ST_RUN) &&
                   $isunknown({bus.we_in, bus.addr_in});
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
`ifndef SYNTHESIS
        if (x_req) begin
            $warning("sram_1rw_pipe: X on we_in/addr_in, array corrupted");
            for (int i = 0; i < WORD_DEPTH; i++) begin
                mem[i] <= 'x;
            end
        end
`endif
    end

    // ---------------- optional extra response stage (READ_LATENCY=2) ----------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic            vld_p0_q, vld_p0_d;
            logic            err_p0_q, err_p0_d;
            logic [BITS-1:0] data_p0_q, data_p0_d;

            always_comb begin
                vld_p0_d  = accept;
                err_p0_d  = accept && !in_range;
                data_p0_d = accept ? resp_data : data_p0_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p0_q <= 1'b0;
                    err_p0_q <= 1'b0;
                end else begin
                    vld_p0_q <= vld_p0_d;
                    err_p0_q <= err_p0_d;
                end
            end

            always_ff @(posedge clk) begin
                data_p0_q <= data_p0_d;
            end

            assign src_vld  = vld_p0_q;
            assign src_err  = err_p0_q;
            assign src_data = data_p0_q;
        end else begin : g_lat1
            assign src_vld  = accept;
            assign src_err  = accept && !in_range;
            assign src_data = resp_data;
        end
    endgenerate

    // ---------------- response output stage ----------------
    always_comb begin
        rd_valid_d = src_vld;
        err_d      = src_vld && src_err;
        // rd_out holds between strobes so it never shows stale X or junk.
        rd_d       = src_vld ? src_data : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.rd_valid_out = rd_valid_q;
    assign bus.err_out      = err_q;
    assign bus.rd_out       = rd_q;

endmodule

// File: tb/tb_sram_1rw_pipe.sv
// tb_sram_1rw_pipe: scoreboard bench driving two sram_1rw_pipe instances
// with identical requests: dut_a (READ_LATENCY=1, WRITE_FIRST=0) and
// dut_b (READ_LATENCY=2, WRITE_FIRST=1), both BITS=32, WORD_DEPTH=5.
`timescale 1ns/1ps
module tb_sram_1rw_pipe;
    localparam int BITS = 32;
    localparam int WD   = 5;
    localparam int AW   = 3;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] model [WD];
    exp_t        qa[$];
    exp_t        qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_1rw_pipe_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus_a ();
    sram_1rw_pipe_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_b.req_valid_in = bus_a.req_valid_in;
    assign bus_b.addr_in      = bus_a.addr_in;
    assign bus_b.we_in        = bus_a.we_in;
    assign bus_b.wd_in        = bus_a.wd_in;
    assign bus_b.w_mask_in    = bus_a.w_mask_in;

    sram_1rw_pipe #(
        .BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW),
        .READ_LATENCY(1), .WRITE_FIRST(0), .INIT_ZERO(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    sram_1rw_pipe #(
        .BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW),
        .READ_LATENCY(2), .WRITE_FIRST(1), .INIT_ZERO(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", n, act, req, cyc);
        end
    endtask

    function automatic int qsize(input int w);
        if (w == 0) return qa.size();
        return qb.size();
    endfunction

    function automatic int qdue(input int w);
        if (w == 0) return qa[0].due;
        return qb[0].due;
    endfunction

    function automatic exp_t qpop(input int w);
        if (w == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    // Monitor: pops the oldest expectation whenever a response strobe shows up.
    task automatic mon(input string t, input logic v, input logic [31:0] d,
                       input logic e, input int w);
        exp_t x;
        if (v) begin
            if (qsize(w) == 0) begin
                total++;
                bad++;
                $display("FAIL %s_spurious: rd_valid_out=1 rd_out=%h, required no response", t, d);
            end else begin
                x = qpop(w);
                chk({t, "_data"}, d, x.data);
                chk({t, "_err"}, 32'(e), 32'(x.err));
                chk({t, "_cycle"}, cyc, x.due);
            end
        end else begin
            if (e) begin
                total++;
                bad++;
                $display("FAIL %s_err_strobe: err_out=1 with rd_valid_out=0, required 0", t);
            end
            if (qsize(w) > 0 && qdue(w) < cyc) begin
                x = qpop(w);
                total++;
                bad++;
                $display("FAIL %s_missing: no response by cycle %0d, required data %h due %0d",
                         t, cyc, x.data, x.due);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon("a", bus_a.rd_valid_out, bus_a.rd_out, bus_a.err_out, 0);
            mon("b", bus_b.rd_valid_out, bus_b.rd_out, bus_b.err_out, 1);
        end
    end

    // Presents one request for exactly one cycle (caller keeps it back-to-back
    // by calling again, or ends the burst with idle()).
    task automatic issue(input logic we, input int addr,
                         input logic [31:0] wd, input logic [31:0] mask);
        exp_t        ea, eb;
        logic [31:0] old_w, new_w;
        logic [2:0]  ai;
        ai = 3'(addr);
        @(negedge clk);
        bus_a.req_valid_in = 1'b1;
        bus_a.we_in        = we;
        bus_a.addr_in      = ai;
        bus_a.wd_in        = wd;
        bus_a.w_mask_in    = mask;
        if (addr >= WD) begin
            ea.data = '0;
            ea.err  = 1'b1;
            eb.data = '0;
            eb.err  = 1'b1;
        end else begin
            old_w   = model[ai];
            new_w   = (wd & mask) | (old_w & ~mask);
            ea.data = old_w;
            eb.data = we ? new_w : old_w;
            ea.err  = 1'b0;
            eb.err  = 1'b0;
            if (we) model[ai] = new_w;
        end
        ea.due = cyc + 1;
        eb.due = cyc + 2;
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic idle();
        @(negedge clk);
        bus_a.req_valid_in = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) @(negedge clk);
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
    endtask

    task automatic readback();
        for (int i = 0; i < WD; i++) issue(1'b0, i, 32'h0, 32'h0);
        drain();
    endtask

    task automatic check_reset_outputs(input string t);
        chk({t, "_a_rd"},     bus_a.rd_out, 32'h0);
        chk({t, "_a_vld"},    32'(bus_a.rd_valid_out), 32'd0);
        chk({t, "_a_err"},    32'(bus_a.err_out), 32'd0);
        chk({t, "_a_ready"},  32'(bus_a.req_ready_out), 32'd0);
        chk({t, "_a_idone"},  32'(bus_a.init_done_out), 32'd0);
        chk({t, "_b_rd"},     bus_b.rd_out, 32'h0);
        chk({t, "_b_vld"},    32'(bus_b.rd_valid_out), 32'd0);
        chk({t, "_b_err"},    32'(bus_b.err_out), 32'd0);
        chk({t, "_b_ready"},  32'(bus_b.req_ready_out), 32'd0);
        chk({t, "_b_idone"},  32'(bus_b.init_done_out), 32'd0);
    endtask

    // Releases reset with a read held valid throughout init; it must not be
    // taken, and ready/init_done must rise after exactly WD edges.
    task automatic init_check();
        int k;
        bit seen;
        for (int i = 0; i < WD; i++) model[i] = 32'h0;
        bus_a.req_valid_in = 1'b1;
        bus_a.we_in        = 1'b0;
        bus_a.addr_in      = '0;
        @(negedge clk);
        rst_n = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < WD + 4) begin
            @(posedge clk);
            #1;
            k++;
            chk("init_ready_a", 32'(bus_a.req_ready_out), 32'(k >= WD));
            chk("init_done_a",  32'(bus_a.init_done_out), 32'(k >= WD));
            chk("init_ready_b", 32'(bus_b.req_ready_out), 32'(k >= WD));
            chk("init_done_b",  32'(bus_b.init_done_out), 32'(k >= WD));
            if (bus_a.req_ready_out) seen = 1'b1;
        end
        bus_a.req_valid_in = 1'b0;
        chk("init_edges", 32'(k), 32'(WD));
    endtask

    initial begin
        int pipe_addrs [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
        logic [31:0] m;
        bus_a.req_valid_in = 1'b0;
        bus_a.we_in        = 1'b0;
        bus_a.addr_in      = '0;
        bus_a.wd_in        = '0;
        bus_a.w_mask_in    = '0;
        rst_n              = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        init_check();

        // Cleared array
        readback();

        // Masked write then read of the same word, back to back
        issue(1'b1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1'b1, 3, 32'h1234_5678, 32'h0000_FFFF);
        issue(1'b0, 3, 32'h0, 32'h0);
        drain();

        // Old-word vs merged-word write response
        issue(1'b1, 2, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        issue(1'b1, 2, 32'h5555_5555, 32'hFFFF_FFFF);
        drain();

        // Out-of-range addresses, including the first one past the end
        issue(1'b1, 6, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        issue(1'b0, 6, 32'h0, 32'h0);
        issue(1'b1, 5, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        issue(1'b0, 7, 32'h0, 32'h0);
        drain();
        readback();

        // Back-to-back read burst
        foreach (pipe_addrs[i]) issue(1'b0, pipe_addrs[i], 32'h0, 32'h0);
        drain();

        // Randomised traffic with idle gaps
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                case ($urandom_range(0, 2))
                    0:       m = 32'hFFFF_FFFF;
                    1:       m = $urandom;
                    default: m = 32'h0;
                endcase
                issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, m);
            end
        end
        drain();
        readback();

        // Reset while two reads are in flight
        issue(1'b0, 3, 32'h0, 32'h0);
        issue(1'b0, 4, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus_a.req_valid_in = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (3) begin
            @(negedge clk);
            chk("midrst_hold_a_vld", 32'(bus_a.rd_valid_out), 32'd0);
            chk("midrst_hold_b_vld", 32'(bus_b.rd_valid_out), 32'd0);
        end
        init_check();
        readback();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
